// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory-bus arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam int                TIMEOUT_CYCLES_DEF = 256;
  localparam logic [DATA_W-1:0] ERR_RDATA_DEF      = 32'hDEADBEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_2_1_rr_pick_2.sv
// Combinational two-way round-robin picker: on contention the side not served last wins.
module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       any
);

  always_comb begin
    any     = |req;
    gnt_idx = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/mem_arbiter_2_1.sv
// Round-robin arbiter sharing one valid/ready memory slave between two requesters.
// Optional forced completion of stalled transactions under `MEM_ARB_TIMEOUT_EN`.
module mem_arbiter_2_1
  import mem_arb_pkg::*;
#(
  parameter logic              PRIO_INIT      = 1'b0,
  parameter int                TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_mem_valid0,
  input  logic              s_mem_valid1,
  output logic              s_mem_ready0,
  output logic              s_mem_ready1,
  input  logic [ADDR_W-1:0] s_mem_addr0,
  input  logic [ADDR_W-1:0] s_mem_addr1,
  input  logic [DATA_W-1:0] s_mem_wdata0,
  input  logic [DATA_W-1:0] s_mem_wdata1,
  input  logic [STRB_W-1:0] s_mem_wstrb0,
  input  logic [STRB_W-1:0] s_mem_wstrb1,
  output logic [DATA_W-1:0] s_mem_rdata0,
  output logic [DATA_W-1:0] s_mem_rdata1,
  output logic              m_mem_valid,
  input  logic              m_mem_ready,
  output logic [ADDR_W-1:0] m_mem_addr,
  output logic [DATA_W-1:0] m_mem_wdata,
  output logic [STRB_W-1:0] m_mem_wstrb,
  input  logic [DATA_W-1:0] m_mem_rdata,
  output logic              arb_busy,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              arb_timeout,
`endif
  output logic              arb_grant
);

  arb_state_t r_state, w_state_nxt;
  logic       r_grant, w_grant_nxt;
  logic       r_last, w_last_nxt;
  logic       w_pick_idx, w_pick_any;
  logic       w_busy, w_gnt_vld, w_done, w_tmo, w_fin;

  rr_pick_2 u_pick (
    .req     ({s_mem_valid1, s_mem_valid0}),
    .last    (r_last),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  assign w_busy    = (r_state == BUSY);
  assign w_gnt_vld = r_grant ? s_mem_valid1 : s_mem_valid0;
  // Slave ready only counts while the granted requester still holds valid.
  assign w_done    = w_busy & w_gnt_vld & m_mem_ready;
  assign w_fin     = w_done | w_tmo;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  assign w_tmo = w_busy & w_gnt_vld & ~m_mem_ready &
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_busy)
        r_cnt <= '0;
      else if (!m_mem_ready)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_tmo)
        r_timeout <= 1'b1;
    end
  end

  assign arb_timeout = r_timeout;
`else
  logic w_unused;

  assign w_tmo    = 1'b0;
  assign w_unused = ^{ERR_RDATA, TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= PRIO_INIT;
      r_last  <= ~PRIO_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A requester abandoning its request does not count as being served.
        if (!w_gnt_vld) begin
          w_state_nxt = IDLE;
        end else if (w_fin) begin
          w_last_nxt  = r_grant;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_mem_valid  = w_busy & w_gnt_vld;
    s_mem_ready0 = w_fin & ~r_grant;
    s_mem_ready1 = w_fin & r_grant;
    s_mem_rdata0 = m_mem_rdata & {DATA_W{w_busy & ~r_grant}};
    s_mem_rdata1 = m_mem_rdata & {DATA_W{w_busy & r_grant}};
    if (w_tmo & ~r_grant)
      s_mem_rdata0 = ERR_RDATA;
    if (w_tmo & r_grant)
      s_mem_rdata1 = ERR_RDATA;
    arb_busy  = w_busy;
    arb_grant = r_grant;
    m_mem_addr  = '0;
    m_mem_wdata = '0;
    m_mem_wstrb = '0;
    if (resetn) begin
      m_mem_addr  = r_grant ? s_mem_addr1  : s_mem_addr0;
      m_mem_wdata = r_grant ? s_mem_wdata1 : s_mem_wdata0;
      m_mem_wstrb = r_grant ? s_mem_wstrb1 : s_mem_wstrb0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2_1.sv
// Directed, table-driven bench for mem_arbiter_2_1 (timeout sequence only with MEM_ARB_TIMEOUT_EN).
module tb_mem_arbiter_2_1;

  localparam logic [31:0] ADDR0  = 32'h0000_0100;
  localparam logic [31:0] WDATA0 = 32'h1111_2222;
  localparam logic [3:0]  WSTRB0 = 4'h0;
  localparam logic [31:0] ADDR1  = 32'h1000_0004;
  localparam logic [31:0] WDATA1 = 32'hA5A5_A5A5;
  localparam logic [3:0]  WSTRB1 = 4'hF;
  localparam logic [31:0] C = 32'hCAFE_0000;
  localparam logic [31:0] R = 32'h1234_5678;
  localparam logic [31:0] S = 32'h55AA_55AA;
  localparam logic [1:0]  FA = 2'd0, FB = 2'd1, FZ = 2'd2;
  localparam int NVEC = 26;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_mem_valid0, s_mem_valid1;
  logic        s_mem_ready0, s_mem_ready1;
  logic [31:0] s_mem_rdata0, s_mem_rdata1;
  logic        m_mem_valid, m_mem_ready;
  logic [31:0] m_mem_addr, m_mem_wdata, m_mem_rdata;
  logic [3:0]  m_mem_wstrb;
  logic        arb_busy, arb_grant;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        arb_timeout;
`endif

  always #5 clk = ~clk;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arbiter_2_1 #(.PRIO_INIT(1'b0), .TIMEOUT_CYCLES(16)) dut (
`else
  mem_arbiter_2_1 #(.PRIO_INIT(1'b0)) dut (
`endif
    .clk          (clk),
    .resetn       (resetn),
    .s_mem_valid0 (s_mem_valid0),
    .s_mem_valid1 (s_mem_valid1),
    .s_mem_ready0 (s_mem_ready0),
    .s_mem_ready1 (s_mem_ready1),
    .s_mem_addr0  (ADDR0),
    .s_mem_addr1  (ADDR1),
    .s_mem_wdata0 (WDATA0),
    .s_mem_wdata1 (WDATA1),
    .s_mem_wstrb0 (WSTRB0),
    .s_mem_wstrb1 (WSTRB1),
    .s_mem_rdata0 (s_mem_rdata0),
    .s_mem_rdata1 (s_mem_rdata1),
    .m_mem_valid  (m_mem_valid),
    .m_mem_ready  (m_mem_ready),
    .m_mem_addr   (m_mem_addr),
    .m_mem_wdata  (m_mem_wdata),
    .m_mem_wstrb  (m_mem_wstrb),
    .m_mem_rdata  (m_mem_rdata),
    .arb_busy     (arb_busy),
`ifdef MEM_ARB_TIMEOUT_EN
    .arb_timeout  (arb_timeout),
`endif
    .arb_grant    (arb_grant)
  );

  typedef struct {
    logic [3:0]  in_bits;   // {resetn, valid0, valid1, m_ready}
    logic [31:0] rd;
    logic [4:0]  exp_bits;  // {m_valid, ready0, ready1, busy, grant}
    logic [1:0]  f;         // forwarded fields: requester 0, requester 1, or zero
    logic [31:0] e0, e1;
  } vec_t;

  vec_t tbl [NVEC];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [3:0] ib, input logic [31:0] rd,
                              input logic [4:0] eb, input logic [1:0] f,
                              input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.in_bits = ib; v.rd = rd; v.exp_bits = eb; v.f = f; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] fwd(input logic [1:0] f);
    case (f)
      FA:      return {ADDR0, WDATA0, WSTRB0};
      FB:      return {ADDR1, WDATA1, WSTRB1};
      default: return '0;
    endcase
  endfunction

  initial begin
    int n;
    logic got;
    tbl[0]  = mk(4'b0000, 0, 5'b00000, FZ, 0, 0);
    tbl[1]  = mk(4'b1111, C, 5'b00000, FA, 0, 0);
    tbl[2]  = mk(4'b1111, C, 5'b11010, FA, C, 0);
    tbl[3]  = mk(4'b1111, C, 5'b00000, FA, 0, 0);
    tbl[4]  = mk(4'b1111, C, 5'b10111, FB, 0, C);
    tbl[5]  = mk(4'b1111, C, 5'b00001, FB, 0, 0);
    tbl[6]  = mk(4'b1111, C, 5'b11010, FA, C, 0);
    tbl[7]  = mk(4'b1010, 0, 5'b00000, FA, 0, 0);
    tbl[8]  = mk(4'b1010, C, 5'b10011, FB, 0, C);
    tbl[9]  = mk(4'b1010, C, 5'b10011, FB, 0, C);
    tbl[10] = mk(4'b1011, C, 5'b10111, FB, 0, C);
    tbl[11] = mk(4'b1000, C, 5'b00001, FB, 0, 0);
    tbl[12] = mk(4'b1101, R, 5'b00001, FB, 0, 0);
    tbl[13] = mk(4'b1101, R, 5'b11010, FA, R, 0);
    tbl[14] = mk(4'b1000, R, 5'b00000, FA, 0, 0);
    tbl[15] = mk(4'b1010, R, 5'b00000, FA, 0, 0);
    tbl[16] = mk(4'b1010, R, 5'b10011, FB, 0, R);
    tbl[17] = mk(4'b0010, R, 5'b10011, FZ, 0, R);
    tbl[18] = mk(4'b1010, R, 5'b00000, FA, 0, 0);
    tbl[19] = mk(4'b1011, S, 5'b10111, FB, 0, S);
    tbl[20] = mk(4'b1110, S, 5'b00001, FB, 0, 0);
    tbl[21] = mk(4'b1110, S, 5'b10010, FA, S, 0);
    tbl[22] = mk(4'b1011, S, 5'b00010, FA, S, 0);
    tbl[23] = mk(4'b1010, S, 5'b00000, FA, 0, 0);
    tbl[24] = mk(4'b1011, S, 5'b10111, FB, 0, S);
    tbl[25] = mk(4'b1000, 0, 5'b00001, FB, 0, 0);

    resetn = 1'b0; s_mem_valid0 = 1'b0; s_mem_valid1 = 1'b0;
    m_mem_ready = 1'b0; m_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      {resetn, s_mem_valid0, s_mem_valid1, m_mem_ready} = tbl[i].in_bits;
      m_mem_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {m_mem_valid, s_mem_ready0, s_mem_ready1, arb_busy, arb_grant,
           m_mem_addr, m_mem_wdata, m_mem_wstrb, s_mem_rdata0, s_mem_rdata1},
          {tbl[i].exp_bits, fwd(tbl[i].f), tbl[i].e0, tbl[i].e1});
      @(posedge clk);
      #1;
    end

    // Zero-wait read on requester 0 completes in exactly two cycles.
    s_mem_valid0 = 1'b1; m_mem_ready = 1'b1; m_mem_rdata = R;
    n = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      n++;
      if (s_mem_ready0) begin
        got = 1'b1;
        chk("lat_rdata", {105'd0, s_mem_rdata0, s_mem_rdata1}, {105'd0, R, 32'd0});
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("lat_cycles", {136'(n), got}, {136'd2, 1'b1});
    @(posedge clk);
    #1;
    s_mem_valid0 = 1'b0; m_mem_ready = 1'b0; m_mem_rdata = '0;
    @(negedge clk);
    chk("lat_idle", {135'd0, arb_busy, s_mem_ready0}, 137'd0);
    @(posedge clk);
    #1;

`ifdef MEM_ARB_TIMEOUT_EN
    chk("tmo_clear", {136'd0, arb_timeout}, 137'd0);
    s_mem_valid0 = 1'b1;
    @(posedge clk);
    #1;
    n = 0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      n++;
      if (s_mem_ready0) begin
        got = 1'b1;
        chk("tmo_rdata", {105'd0, s_mem_rdata0, s_mem_ready1}, {105'd0, 32'hDEADBEEF, 1'b0});
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("tmo_cycles", {136'(n), got}, {136'd16, 1'b1});
    @(posedge clk);
    #1;
    s_mem_valid0 = 1'b0;
    @(negedge clk);
    chk("tmo_set", {135'd0, arb_timeout, arb_busy}, {135'd0, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tmo_sticky", {136'd0, arb_timeout}, {136'd0, 1'b1});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2_1.md
Name: mem_arbiter_2_1

Overview:
Round-robin arbiter that shares one 32-bit valid/ready memory-bus slave (e.g. the address-decoding mux feeding RAM/peripherals) between two requesters, such as CPU and AES DMA engine.
- Locks the grant for a whole transaction.
- Forwards the granted requester's addr/wdata/wstrb downstream.
- Returns ready only to the granted requester.
- Sits between the requesters and the address-decode mux.

Parameters:
PRIO_INIT, 1'b0, requester preferred on the first arbitration after reset.
TIMEOUT_CYCLES, 256, cycles in BUSY before forced completion (used only with MEM_ARB_TIMEOUT_EN).
ERR_RDATA, 32'hDEADBEEF, rdata returned on timeout (used only with MEM_ARB_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
s_mem_valid0 / s_mem_valid1  input  1  request from requester 0 / 1
s_mem_ready0 / s_mem_ready1  output  1  completion to requester 0 / 1
s_mem_addr0 / s_mem_addr1  input  32  request address
s_mem_wdata0 / s_mem_wdata1  input  32  write data
s_mem_wstrb0 / s_mem_wstrb1  input  4  byte strobes, 0 = read
s_mem_rdata0 / s_mem_rdata1  output  32  read data
m_mem_valid  output  1  request to shared slave
m_mem_ready  input  1  slave completion
m_mem_addr  output  32  forwarded address
m_mem_wdata  output  32  forwarded write data
m_mem_wstrb  output  4  forwarded strobes
m_mem_rdata  input  32  slave read data
arb_busy  output  1  high while a grant is held
arb_grant  output  1  index of current/last grant

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous, active-low on resetn.
- State: IDLE, BUSY; registers grant (1b), last (1b, init PRIO_INIT ^ 1).
- Reset values:
  - state = IDLE, grant = PRIO_INIT, last = ~PRIO_INIT.
  - All outputs 0: m_mem_valid, s_mem_ready0/1, m_mem_addr, m_mem_wdata, m_mem_wstrb, arb_busy, s_mem_rdata0/1.
  - arb_grant = PRIO_INIT.
- IDLE, no valid: stay.
- IDLE, exactly one valid: grant = that index; go to BUSY.
- IDLE, both valid: grant = ~last (round robin); go to BUSY.
- Arbitration costs 1 cycle. m_mem_valid never asserts in IDLE.
- BUSY:
  - m_mem_valid = s_mem_valid[grant].
  - m_mem_addr/wdata/wstrb = requester[grant] fields.
  - When m_mem_ready is high: s_mem_ready[grant] = 1 in that same cycle (combinational pass-through), last <= grant, state <= IDLE.
- m_mem_addr/wdata/wstrb are muxed by the grant register: held at grant's fields in IDLE, zero only during reset.
- s_mem_rdata0 and s_mem_rdata1 = m_mem_rdata & {32{state==BUSY && grant==i}}.
- s_mem_ready of the non-granted requester is always 0.
- Minimum transaction time: 2 cycles (arbitrate + 0-wait slave). Back-to-back requests from both requesters strictly alternate.
- Granted requester drops valid in BUSY before ready (protocol violation): m_mem_valid falls; state goes to IDLE next cycle; no ready issued; last is unchanged.
- m_mem_ready while m_mem_valid is low: ignored.
- resetn low in any state (including mid-BUSY): next edge forces reset values; the pending transaction is abandoned.
- arb_busy = (state==BUSY); arb_grant = grant.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle without m_mem_ready.
  - When count == TIMEOUT_CYCLES-1: s_mem_ready[grant] = 1, s_mem_rdata[grant] = ERR_RDATA, last <= grant, state <= IDLE.
  - A sticky output arb_timeout (1b, cleared only by reset) sets.
- Undefined: no counter and no arb_timeout port; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE=1'b0, BUSY=1'b1).
  - Default ERR_RDATA and TIMEOUT_CYCLES constants.
  - Mem-bus field widths (ADDR_W=32, DATA_W=32, STRB_W=4).
- Sub-module rr_pick_2: combinational round-robin picker; inputs req[1:0], last; outputs gnt_idx, any.
- Everything else stays inline.

Test Plan:
- Reset with PRIO_INIT=0, then valid0=valid1=1 in the same cycle → grant=0 first, then grant=1; the two transactions alternate.
- Single requester 1, addr=32'h1000_0004, wstrb=4'hF, wdata=32'hA5A5_A5A5, slave ready after 3 cycles:
  - m_mem_* match requester 1's fields.
  - s_mem_ready1 pulses once; s_mem_ready0 stays 0.
- Read on requester 0 with m_mem_rdata=32'h1234_5678, zero-wait slave:
  - s_mem_rdata0 = 32'h1234_5678 in the ready cycle.
  - s_mem_rdata1 = 0.
  - Total 2 cycles.
- resetn deasserted for 1 cycle mid-BUSY with slave stalled → outputs go to reset values; no ready issued; the next request re-arbitrates.
- Granted requester drops valid before ready → return to IDLE; no ready; the other requester waiting gets granted next.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never ready → in BUSY cycle 16: s_mem_ready = 1, rdata = 32'hDEADBEEF, arb_timeout = 1 (sticky).
